// File: rtl/dmem_sized_if.sv
// dmem_sized_if: request/response bus between the load/store unit and dmem_sized.
interface dmem_sized_if #(parameter int ADDR_W = 32);
    logic              req;
    logic              we;
    logic [1:0]        size;
    logic              unsigned_ld;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       w_data;
    logic              ready;
    logic              done;
    logic              err;
    logic [31:0]       r_data;
    logic              init_done;
    modport master (output req, we, size, unsigned_ld, addr, w_data,
                    input  ready, done, err, r_data, init_done);
    modport slave  (input  req, we, size, unsigned_ld, addr, w_data,
                    output ready, done, err, r_data, init_done);
endinterface

// File: rtl/dmem_sized.sv
// dmem_sized: byte-addressable little-endian data memory with sized loads/stores and hardware clear.
// Define DMEM_MISALIGN_TRAP_EN to report misaligned half/word accesses as errors.
module dmem_sized #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 32
) (
    input logic          clk,
    input logic          rst,
    dmem_sized_if.slave  bus
);
    localparam int CW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(DEPTH - 1);
    typedef enum logic [1:0] {CLEAR, IDLE, ACCESS, RESP} state_t;
    state_t state, next;
    logic [CW-1:0]     cnt;
    logic              we_q, uns_q, bad_q;
    logic [1:0]        size_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wd_q, rd_q;
    logic [31:0]       mem [DEPTH];
    logic [ADDR_W-3:0] idx;
    logic [1:0]        lane;
    logic              mis, bad;
    logic [3:0]        be;
    logic [31:0]       wd_rep, ld_val;
    logic [7:0]        b;
    logic [15:0]       h;
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= CLEAR;
        else     state <= next;
    always_comb begin
        next = state == CLEAR  ? (cnt == LAST ? IDLE : CLEAR) :
               state == IDLE   ? (bus.req ? ACCESS : IDLE) :
               state == ACCESS ? RESP : IDLE;
        bus.ready = state == IDLE;
    end
`ifdef DMEM_MISALIGN_TRAP_EN
    assign mis = (size_q == 2'd1 && addr_q[0]) || (size_q == 2'd2 && addr_q[1:0] != 2'd0);
`else
    assign mis = 1'b0;
`endif
    always_comb begin
        idx    = addr_q[ADDR_W-1:2];
        lane   = addr_q[1:0];
        bad    = idx >= (ADDR_W-2)'(DEPTH) || size_q == 2'd3 || mis;
        be     = size_q == 2'd0 ? 4'b0001 << lane :
                 size_q == 2'd1 ? (lane[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        wd_rep = size_q == 2'd0 ? {4{wd_q[7:0]}} :
                 size_q == 2'd1 ? {2{wd_q[15:0]}} : wd_q;
        b      = rd_q[8*lane +: 8];
        h      = lane[1] ? rd_q[31:16] : rd_q[15:0];
        ld_val = size_q == 2'd0 ? {{24{~uns_q & b[7]}}, b} :
                 size_q == 2'd1 ? {{16{~uns_q & h[15]}}, h} : rd_q;
    end
    // Reset forces CLEAR asynchronously, so an aborted store never reaches the array.
    always_ff @(posedge clk)
        if (state == CLEAR)
            mem[cnt] <= '0;
        else if (state == ACCESS && we_q && !bad)
            for (int k = 0; k < 4; k++)
                if (be[k]) mem[idx[CW-1:0]][8*k +: 8] <= wd_rep[8*k +: 8];
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            cnt           <= '0;
            bus.init_done <= 1'b0;
            bus.done      <= 1'b0;
            bus.err       <= 1'b0;
            bus.r_data    <= '0;
            we_q          <= 1'b0;
            uns_q         <= 1'b0;
            size_q        <= '0;
            addr_q        <= '0;
            wd_q          <= '0;
            rd_q          <= '0;
            bad_q         <= 1'b0;
        end else begin
            bus.done <= state == RESP;
            bus.err  <= state == RESP && bad_q;
            if (state == CLEAR) begin
                cnt <= cnt + 1'b1;
                if (cnt == LAST) bus.init_done <= 1'b1;
            end
            if (state == IDLE && bus.req) begin
                we_q   <= bus.we;
                size_q <= bus.size;
                uns_q  <= bus.unsigned_ld;
                addr_q <= bus.addr;
                wd_q   <= bus.w_data;
            end
            if (state == ACCESS) begin
                bad_q <= bad;
                rd_q  <= mem[idx[CW-1:0]];
            end
            if (state == RESP) bus.r_data <= (bad_q || we_q) ? '0 : ld_val;
        end
endmodule

// File: doc/dmem_sized.md
# dmem_sized

Parametrised data memory for the single-cycle/multi-cycle datapath: byte-addressable, little-endian, with byte/halfword/word loads and stores, sign or zero extension on loads, and a req/ready/done handshake. After reset it zero-fills itself with a hardware clear sequence. It sits between the datapath's memory stage and the load/store unit. It replaces the fixed 256×32 memory with a sized, checked, handshaked store.

## Interface
Parameters:
- DEPTH, 256, number of 32-bit words; need not be a power of two.
- ADDR_W, 32, byte-address width.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req  in  1  access request; sampled only while ready=1.
- we  in  1  1=store, 0=load.
- size  in  2  00 byte, 01 halfword, 10 word, 11 reserved.
- unsigned_ld  in  1  1=zero-extend loads, 0=sign-extend.
- addr  in  ADDR_W  byte address.
- w_data  in  32  store data; low byte/half used for sub-word stores.
- ready  out  1  block can accept a request this cycle.
- done  out  1  one-cycle completion pulse, loads and stores.
- err  out  1  one-cycle error pulse, coincident with done.
- r_data  out  32  load result, valid while done=1.
- init_done  out  1  clear sequence finished.

## Operation
- States: CLEAR, IDLE, ACCESS, RESP.
- CLEAR: counter 0..DEPTH-1, writes 32'h0 to one word per cycle; ready=0, init_done=0. After word DEPTH-1 goes to IDLE and sets init_done=1, which holds until the next reset.
- IDLE: ready=1. req=1 at a rising edge means the request is accepted: we/size/unsigned_ld/addr/w_data are captured, and the state goes to ACCESS. The requester holds req until it is accepted. req in any other state is ignored.
- ACCESS: index = addr[ADDR_W-1:2], lane = addr[1:0].
  - Store: writes only the selected byte lanes. Byte: lane k, bits 8k+7:8k, from w_data[7:0]. Half: lanes 2·addr[1] and +1, from w_data[15:0]. Word: all four lanes.
  - Load: reads the whole word into an internal register.
  - Goes to RESP.
- RESP: registers r_data, pulses done, returns to IDLE.
  - Byte and half results are extracted from the selected lane and extended per unsigned_ld.
  - Stores leave r_data at 0.
- Errors: err=1 with done, no memory write, r_data=0. Causes:
  - index ≥ DEPTH;
  - size=11;
  - misalignment, only when the macro is enabled.
- Priority: range and size errors are checked before alignment. A checked access touches no memory.

## Timing
- Reset values: ready=0, done=0, err=0, r_data=0, init_done=0, state=CLEAR.
- Clear takes DEPTH cycles after reset deasserts. ready rises in the cycle after the last clear write.
- Request accepted at edge N:
  - memory write/read at edge N+1;
  - r_data/done/err registered at edge N+2;
  - done high during cycle N+2→N+3, and ready=1 in that same cycle.
- Throughput: one access per 3 cycles. The next request can be accepted at edge N+3.
- Load after store to the same word returns the new data, because the write completes at N+1 and the next read is no earlier than N+4.
- Reset mid-operation:
  - aborts immediately and drops done/err;
  - returns to CLEAR, re-zeroes all words, and clears init_done.

## Configuration
- DMEM_MISALIGN_TRAP_EN defined: misaligned accesses raise err and have no effect. Misaligned means half with addr[0]=1, or word with addr[1:0]≠0.
- Not defined: misalignment is never an error.
  - Half ignores addr[0].
  - Word ignores addr[1:0] (forced alignment).
  - Byte is unaffected either way.

## Test plan
- Reset, then count cycles → ready=0 and init_done=0 for exactly 256 cycles, then both 1; loads of addresses 0x0 and 0x3FC return 0.
- sw 0x8899AABB to 0x10, then lb at 0x12 → 0xFFFFFF99; lbu at 0x12 → 0x00000099; lh at 0x10 → 0xFFFFAABB; lhu at 0x12 → 0x00008899.
- sb 0x5A at 0x11 over word 0x8899AABB, then lw at 0x10 → 0x88995ABB, proving the other lanes are untouched.
- lw at 0x400 (index 256) → done and err pulse together, r_data=0; sw there → err, no aliasing into word 0.
- lw at 0x12 → err=1 with the macro defined; with it undefined, returns word 0x10 and err=0.
- Assert rst during ACCESS of a store to 0x20 → done never pulses, clear restarts, lw at 0x20 afterwards returns 0.
